// File: rtl/data_ram_arbiter_pkg.sv
// Shared types and constants for the two-master data RAM arbiter.
package data_ram_arbiter_pkg;

    // Ownership state of the arbiter: no owner, or locked to master 0 / master 1.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } arb_state_e;

    localparam logic MASTER0 = 1'b0;
    localparam logic MASTER1 = 1'b1;

    // Map a master id to the state in which that master owns the RAM.
    function automatic arb_state_e own_state(input logic id);
        return (id == MASTER1) ? OWN1 : OWN0;
    endfunction

endpackage

// File: rtl/data_ram_arbiter_rr_grant2.sv
// Two-way round-robin arbiter with lock-based ownership and a fairness cap.
// The grant is combinational from the current requests and registered state.
module rr_grant2
    import data_ram_arbiter_pkg::*;
#(
    parameter int MAX_LOCK = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic [1:0] lock,
    output logic [1:0] grant,
    output logic       grant_id
);

    localparam int CNT_W = $clog2(MAX_LOCK + 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_LOCK);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

    arb_state_e       state;
    arb_state_e       state_next;
    logic             last_grant;
    logic             last_grant_next;
    logic [CNT_W-1:0] lock_cnt;
    logic [CNT_W-1:0] lock_cnt_next;

    logic [1:0]       rr_grant;
    logic             owner_id;
    logic             owner_holds;
    logic             lock_full;

    assign owner_id    = (state == OWN1) ? MASTER1 : MASTER0;
    assign owner_holds = req[owner_id] & lock[owner_id];
    assign lock_full   = (lock_cnt == CNT_MAX);
    assign grant_id    = grant[1];

    // Round-robin pick: on a tie the master that was not granted last wins.
    always_comb begin
        rr_grant = 2'b00;
        if (req == 2'b11) begin
            rr_grant = (last_grant == MASTER1) ? 2'b01 : 2'b10;
        end else if (req[1]) begin
            rr_grant = 2'b10;
        end else if (req[0]) begin
            rr_grant = 2'b01;
        end else begin
            rr_grant = 2'b00;
        end
    end

    // Grant selection: a locking owner keeps the RAM until its run is capped
    // and the other master is waiting; otherwise fall back to round-robin.
    always_comb begin
        grant = 2'b00;
        if (reset) begin
            grant = 2'b00;
        end else begin
            case (state)
                OWN0, OWN1: begin
                    if (owner_holds) begin
                        if (lock_full && req[~owner_id]) begin
                            grant = (owner_id == MASTER1) ? 2'b01 : 2'b10;
                        end else begin
                            grant = (owner_id == MASTER1) ? 2'b10 : 2'b01;
                        end
                    end else begin
                        grant = rr_grant;
                    end
                end
                IDLE:    grant = rr_grant;
                default: grant = rr_grant;
            endcase
        end
    end

    // Next ownership, run counter and last-grant tracking. The accept that
    // establishes ownership counts as the first grant of the locked run.
    always_comb begin
        state_next      = IDLE;
        lock_cnt_next   = CNT_ZERO;
        last_grant_next = last_grant;
        if (grant != 2'b00) begin
            last_grant_next = grant_id;
            if (lock[grant_id]) begin
                state_next = own_state(grant_id);
                if (state == own_state(grant_id)) begin
                    lock_cnt_next = lock_full ? lock_cnt : (lock_cnt + CNT_ONE);
                end else begin
                    lock_cnt_next = CNT_ONE;
                end
            end else begin
                state_next    = IDLE;
                lock_cnt_next = CNT_ZERO;
            end
        end else begin
            state_next    = IDLE;
            lock_cnt_next = CNT_ZERO;
        end
    end

    // Arbitration state registers; master 0 wins the first tie after reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            last_grant <= MASTER1;
            lock_cnt   <= CNT_ZERO;
        end else begin
            state      <= state_next;
            last_grant <= last_grant_next;
            lock_cnt   <= lock_cnt_next;
        end
    end

endmodule

// File: rtl/data_ram_arbiter.sv
// Two-master arbiter in front of a single-port synchronous RAM.
// Commands are accepted with zero wait when granted; reads return one cycle
// later on the issuing master only, writes complete in the accept cycle.
module data_ram_arbiter
    import data_ram_arbiter_pkg::*;
#(
    parameter int ADDR_W   = 10,
    parameter int DATA_W   = 32,
    parameter int MAX_LOCK = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [ADDR_W-1:0]   m0_address,
    input  logic [DATA_W/8-1:0] m0_byteenable,
    input  logic                m0_read,
    input  logic                m0_write,
    input  logic                m0_lock,
    input  logic [DATA_W-1:0]   m0_writedata,
    output logic                m0_waitrequest,
    output logic [DATA_W-1:0]   m0_readdata,
    output logic                m0_readdatavalid,
    input  logic [ADDR_W-1:0]   m1_address,
    input  logic [DATA_W/8-1:0] m1_byteenable,
    input  logic                m1_read,
    input  logic                m1_write,
    input  logic                m1_lock,
    input  logic [DATA_W-1:0]   m1_writedata,
    output logic                m1_waitrequest,
    output logic [DATA_W-1:0]   m1_readdata,
    output logic                m1_readdatavalid,
    output logic [ADDR_W-1:0]   ram_address,
    output logic [DATA_W/8-1:0] ram_byteenable,
    output logic [DATA_W-1:0]   ram_writedata,
    output logic                ram_chipselect,
    output logic                ram_write,
    output logic                ram_clken,
    input  logic [DATA_W-1:0]   ram_readdata
);

    logic [1:0] req;
    logic [1:0] lock;
    logic [1:0] grant;
    logic       grant_id;
    logic       any_grant;
    logic       granted_read;
    logic       rd_tag_valid;
    logic       rd_tag_id;

    assign req       = {m1_read | m1_write, m0_read | m0_write};
    assign lock      = {m1_lock, m0_lock};
    assign any_grant = |grant;

    rr_grant2 #(
        .MAX_LOCK (MAX_LOCK)
    ) u_rr_grant2 (
        .clk      (clk),
        .reset    (reset),
        .req      (req),
        .lock     (lock),
        .grant    (grant),
        .grant_id (grant_id)
    );

    assign m0_waitrequest = reset | (req[0] & ~grant[0]);
    assign m1_waitrequest = reset | (req[1] & ~grant[1]);
    assign ram_chipselect = any_grant;
    assign ram_clken      = 1'b1;

    // Steer the granted master onto the RAM port; a write strobe wins over a
    // simultaneous (illegal) read strobe so no read tag is raised for it.
    always_comb begin
        ram_address    = m0_address;
        ram_byteenable = m0_byteenable;
        ram_writedata  = m0_writedata;
        ram_write      = 1'b0;
        granted_read   = 1'b0;
        if (grant_id == MASTER1) begin
            ram_address    = m1_address;
            ram_byteenable = m1_byteenable;
            ram_writedata  = m1_writedata;
            ram_write      = any_grant & m1_write;
            granted_read   = any_grant & m1_read & ~m1_write;
        end else begin
            ram_address    = m0_address;
            ram_byteenable = m0_byteenable;
            ram_writedata  = m0_writedata;
            ram_write      = any_grant & m0_write;
            granted_read   = any_grant & m0_read & ~m0_write;
        end
    end

    // Read tag: remembers which master owns the RAM output next cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_tag_valid <= 1'b0;
            rd_tag_id    <= MASTER0;
        end else begin
            rd_tag_valid <= granted_read;
            rd_tag_id    <= grant_id;
        end
    end

    // Valid is suppressed while reset is held so a read accepted just before
    // reset never reports data.
    assign m0_readdatavalid = rd_tag_valid & (rd_tag_id == MASTER0) & ~reset;
    assign m1_readdatavalid = rd_tag_valid & (rd_tag_id == MASTER1) & ~reset;
    assign m0_readdata      = ram_readdata;
    assign m1_readdata      = ram_readdata;

endmodule

// File: tb/tb_data_ram_arbiter.sv
// Randomized scoreboard bench for data_ram_arbiter with an attached RAM model.
module tb_data_ram_arbiter;

    localparam int ADDR_W   = 10;
    localparam int DATA_W   = 32;
    localparam int BE_W     = 4;
    localparam int MAX_LOCK = 16;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [ADDR_W-1:0] m0_address, m1_address;
    logic [BE_W-1:0]   m0_byteenable, m1_byteenable;
    logic              m0_read, m0_write, m0_lock, m1_read, m1_write, m1_lock;
    logic [DATA_W-1:0] m0_writedata, m1_writedata;
    logic              m0_waitrequest, m1_waitrequest;
    logic [DATA_W-1:0] m0_readdata, m1_readdata;
    logic              m0_readdatavalid, m1_readdatavalid;
    logic [ADDR_W-1:0] ram_address;
    logic [BE_W-1:0]   ram_byteenable;
    logic [DATA_W-1:0] ram_writedata;
    logic              ram_chipselect, ram_write, ram_clken;
    logic [DATA_W-1:0] ram_readdata;

    always #5 clk = ~clk;

    data_ram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_LOCK(MAX_LOCK)) dut (
        .clk(clk), .reset(reset),
        .m0_address(m0_address), .m0_byteenable(m0_byteenable), .m0_read(m0_read),
        .m0_write(m0_write), .m0_lock(m0_lock), .m0_writedata(m0_writedata),
        .m0_waitrequest(m0_waitrequest), .m0_readdata(m0_readdata),
        .m0_readdatavalid(m0_readdatavalid),
        .m1_address(m1_address), .m1_byteenable(m1_byteenable), .m1_read(m1_read),
        .m1_write(m1_write), .m1_lock(m1_lock), .m1_writedata(m1_writedata),
        .m1_waitrequest(m1_waitrequest), .m1_readdata(m1_readdata),
        .m1_readdatavalid(m1_readdatavalid),
        .ram_address(ram_address), .ram_byteenable(ram_byteenable),
        .ram_writedata(ram_writedata), .ram_chipselect(ram_chipselect),
        .ram_write(ram_write), .ram_clken(ram_clken), .ram_readdata(ram_readdata)
    );

    // Single-port RAM attached to the DUT: byte-lane writes, 1-cycle read.
    logic [DATA_W-1:0] tb_ram [0:1023] = '{default: 32'h0};
    logic [DATA_W-1:0] ram_q = 32'h0;
    assign ram_readdata = ram_q;

    always @(posedge clk) begin
        if (ram_chipselect && ram_clken) begin
            if (ram_write) begin
                for (int b = 0; b < BE_W; b++)
                    if (ram_byteenable[b]) tb_ram[ram_address][8*b +: 8] <= ram_writedata[8*b +: 8];
            end else begin
                ram_q <= tb_ram[ram_address];
            end
        end
    end

    typedef struct {
        bit                rd;
        bit                wr;
        logic [ADDR_W-1:0] addr;
        logic [BE_W-1:0]   be;
        logic [DATA_W-1:0] data;
        bit                lock;
    } cmd_t;

    typedef struct {
        logic [DATA_W-1:0] data;
        int                stamp;
    } exp_t;

    cmd_t              cmdq [2][$];
    exp_t              expq [2][$];
    int                glog [$];
    logic [DATA_W-1:0] ref_mem [0:1023] = '{default: 32'h0};
    logic [DATA_W-1:0] last_rd [2];
    int                n_checks = 0;
    int                n_pass = 0;
    int                cyc = 0;
    int                n_run;
    int                mdl_owner = -1;
    int                mdl_run = 0;
    int                mdl_last = 1;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    endtask

    function automatic cmd_t mk(bit rd, bit wr, logic [ADDR_W-1:0] a, logic [BE_W-1:0] be,
                                logic [DATA_W-1:0] d, bit lk);
        cmd_t c;
        c.rd = rd; c.wr = wr; c.addr = a; c.be = be; c.data = d; c.lock = lk;
        return c;
    endfunction

    function automatic cmd_t rand_cmd();
        bit                rd;
        logic [ADDR_W-1:0] a;
        logic [BE_W-1:0]   be;
        rd = bit'($urandom_range(0, 1));
        a  = ADDR_W'($urandom_range(0, 15));
        be = BE_W'($urandom_range(0, 15));
        return mk(rd, !rd, a, be, $urandom, ($urandom_range(0, 2) == 0));
    endfunction

    // Reference arbiter: who should win this cycle, from requests, locks and
    // the owner/run/last bookkeeping of the model.
    function automatic int mdl_pick(bit [1:0] r, bit [1:0] l);
        if (mdl_owner >= 0 && r[mdl_owner] && l[mdl_owner]) begin
            if (mdl_run >= MAX_LOCK && r[1-mdl_owner]) return 1 - mdl_owner;
            return mdl_owner;
        end
        if (r[0] && r[1]) return 1 - mdl_last;
        if (r[0]) return 0;
        if (r[1]) return 1;
        return -1;
    endfunction

    task automatic apply(input cmd_t c, input int m);
        exp_t e;
        if (c.wr)
            for (int b = 0; b < BE_W; b++)
                if (c.be[b]) ref_mem[c.addr][8*b +: 8] = c.data[8*b +: 8];
        if (c.rd) begin
            e.data  = ref_mem[c.addr];
            e.stamp = cyc;
            expq[m].push_back(e);
        end
    endtask

    task automatic do_cycle(input bit rst);
        cmd_t     c [2];
        bit [1:0] r, l, acc;
        int       w;
        @(negedge clk);
        reset = rst;
        for (int m = 0; m < 2; m++)
            c[m] = (cmdq[m].size() > 0) ? cmdq[m][0] : mk(0, 0, '0, '0, '0, 0);
        m0_read = c[0].rd; m0_write = c[0].wr; m0_address = c[0].addr;
        m0_byteenable = c[0].be; m0_writedata = c[0].data; m0_lock = c[0].lock;
        m1_read = c[1].rd; m1_write = c[1].wr; m1_address = c[1].addr;
        m1_byteenable = c[1].be; m1_writedata = c[1].data; m1_lock = c[1].lock;
        if (rst) begin
            expq[0].delete();
            expq[1].delete();
        end
        #1;
        for (int m = 0; m < 2; m++) begin
            r[m] = c[m].rd | c[m].wr;
            l[m] = c[m].lock;
        end
        w = rst ? -1 : mdl_pick(r, l);
        chk("m0_waitrequest", m0_waitrequest, rst | (r[0] && w != 0));
        chk("m1_waitrequest", m1_waitrequest, rst | (r[1] && w != 1));
        chk("ram_chipselect", ram_chipselect, w >= 0);
        if (rst) chk("ram_write_in_reset", ram_write, 1'b0);
        acc[0] = r[0] && !m0_waitrequest;
        acc[1] = r[1] && !m1_waitrequest;
        if (rst) begin
            mdl_owner = -1; mdl_run = 0; mdl_last = 1;
        end else if (w >= 0) begin
            if (l[w]) begin
                mdl_run   = (mdl_owner == w) ? ((mdl_run < MAX_LOCK) ? mdl_run + 1 : MAX_LOCK) : 1;
                mdl_owner = w;
            end else begin
                mdl_owner = -1; mdl_run = 0;
            end
            mdl_last = w;
        end else begin
            mdl_owner = -1; mdl_run = 0;
        end
        for (int m = 0; m < 2; m++)
            if (acc[m]) begin
                glog.push_back(m);
                apply(c[m], m);
                void'(cmdq[m].pop_front());
            end
    endtask

    task automatic idle(input int n);
        repeat (n) do_cycle(1'b0);
    endtask

    task automatic run_until_empty(input int budget, output int n);
        n = 0;
        while ((cmdq[0].size() > 0 || cmdq[1].size() > 0) && n < budget) begin
            do_cycle(1'b0);
            n++;
        end
        chk("drain_timeout", cmdq[0].size() + cmdq[1].size(), 0);
        cmdq[0].delete();
        cmdq[1].delete();
    endtask

    // Monitor: pops the scoreboard whenever a read result is due and compares.
    initial begin
        bit ev;
        forever begin
            @(negedge clk);
            #2;
            for (int m = 0; m < 2; m++) begin
                ev = (expq[m].size() > 0) && (expq[m][0].stamp + 1 == cyc);
                chk($sformatf("m%0d_readdatavalid", m),
                    (m == 0) ? m0_readdatavalid : m1_readdatavalid, ev);
                if (ev) begin
                    last_rd[m] = (m == 0) ? m0_readdata : m1_readdata;
                    chk($sformatf("m%0d_readdata", m), last_rd[m], expq[m][0].data);
                    void'(expq[m].pop_front());
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int k;
        m0_read = 1'b0; m0_write = 1'b0; m0_lock = 1'b0; m0_address = '0;
        m0_byteenable = '0; m0_writedata = '0;
        m1_read = 1'b0; m1_write = 1'b0; m1_lock = 1'b0; m1_address = '0;
        m1_byteenable = '0; m1_writedata = '0;
        last_rd[0] = 32'h0; last_rd[1] = 32'h0;
        repeat (3) do_cycle(1'b1);

        // Write then read back on master 0.
        cmdq[0].push_back(mk(0, 1, 10'h005, 4'hF, 32'hDEADBEEF, 0));
        cmdq[0].push_back(mk(1, 0, 10'h005, 4'h0, 32'h0, 0));
        run_until_empty(20, n_run);
        idle(2);
        chk("wr_rd_deadbeef", last_rd[0], 32'hDEADBEEF);

        // Both masters stream reads from reset: strict alternation, no bubbles.
        repeat (2) do_cycle(1'b1);
        glog.delete();
        for (int i = 0; i < 4; i++) begin
            cmdq[0].push_back(mk(1, 0, ADDR_W'(i), 4'h0, 32'h0, 0));
            cmdq[1].push_back(mk(1, 0, ADDR_W'(16 + i), 4'h0, 32'h0, 0));
        end
        run_until_empty(40, n_run);
        chk("alt_cycles", n_run, 8);
        chk("alt_count", glog.size(), 8);
        for (int i = 0; i < 8 && i < glog.size(); i++)
            chk($sformatf("alt_grant%0d", i), glog[i], i % 2);
        idle(2);

        // Master 1 locked write burst with master 0 waiting: 16 then switch.
        glog.delete();
        for (int i = 0; i < 20; i++)
            cmdq[1].push_back(mk(0, 1, ADDR_W'(32 + i), 4'hF, 32'h1000 + i, 1));
        do_cycle(1'b0);
        cmdq[0].push_back(mk(1, 0, 10'h021, 4'h0, 32'h0, 0));
        run_until_empty(60, n_run);
        k = 0;
        while (k < glog.size() && glog[k] == 1) k++;
        chk("lock_run_len", k, 16);
        chk("lock_total_grants", glog.size(), 21);
        idle(2);

        // Partial byte write merges into existing word.
        cmdq[0].push_back(mk(0, 1, 10'h3FF, 4'hF, 32'hFFFFFFFF, 0));
        cmdq[0].push_back(mk(0, 1, 10'h3FF, 4'h1, 32'h000000AA, 0));
        cmdq[0].push_back(mk(1, 0, 10'h3FF, 4'h0, 32'h0, 0));
        run_until_empty(20, n_run);
        idle(2);
        chk("byte_merge", last_rd[0], 32'hFFFFFFAA);

        // Reset right after a read accept; first tie after release goes to m0.
        cmdq[0].push_back(mk(1, 0, 10'h005, 4'h0, 32'h0, 0));
        do_cycle(1'b0);
        cmdq[0].push_back(mk(1, 0, 10'h3FF, 4'h0, 32'h0, 0));
        cmdq[1].push_back(mk(1, 0, 10'h005, 4'h0, 32'h0, 0));
        repeat (2) do_cycle(1'b1);
        glog.delete();
        run_until_empty(10, n_run);
        chk("tie_after_reset_count", glog.size(), 2);
        if (glog.size() > 0) chk("tie_after_reset_m0", glog[0], 0);
        idle(2);

        // Randomized traffic with locks, hazards on a small address window.
        for (int i = 0; i < 400; i++) begin
            for (int m = 0; m < 2; m++)
                if (cmdq[m].size() == 0 && $urandom_range(0, 3) != 0)
                    cmdq[m].push_back(rand_cmd());
            do_cycle(1'b0);
        end
        run_until_empty(200, n_run);
        idle(3);
        chk("scoreboard_empty", expq[0].size() + expq[1].size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
